// File: rtl/game_clock_pkg.sv
// Shared definitions for the game_clock slice.
//   state_e           : controller state encoding (2 bits)
//   BCD_MAX_SEC_TENS  : wrap value of the seconds-tens digit
//   BCD_NINE          : wrap value of all other digits
package game_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_MAXED   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] BCD_NINE         = 4'd9;

endpackage

// File: rtl/game_clock_bcd_digit.sv
// Single BCD digit counter with configurable wrap value.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous zero (takes priority over inc)
//   inc      : advance by one this cycle
//   freeze   : suppress the advance (saturation hold)
//   digit    : current digit value
//   carry    : inc requested while the digit sits at WRAP; does not depend
//              on freeze so the top can use the last carry as the
//              saturation detect without forming a loop
module game_clock_bcd_digit
  import game_clock_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_NINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       freeze,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc && !freeze) begin
      digit_d = (digit_q == WRAP) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q == WRAP);

endmodule

// File: rtl/game_clock.sv
// Elapsed-time clock for a Sudoku session, displayed as BCD MM:SS.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin/resume counting (IDLE or PAUSED)
//   pause         : suspend counting (RUNNING)
//   clear         : zero time and return to IDLE (highest priority)
//   one_ms_pulse  : 1 ms tick from the ms timer
//   timer_enable  : ms timer enable, high only while RUNNING
//   sec_ones/sec_tens/min_ones/min_tens : BCD display digits
//   sec_tick      : one-cycle pulse on every completed second
//   maxed         : high while saturated at 99:59
// All outputs come straight from flops.
module game_clock
  import game_clock_pkg::*;
#(
  parameter int MS_PER_SEC = 1000,
  parameter int MS_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       one_ms_pulse,
  output logic       timer_enable,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       sec_tick,
  output logic       maxed
);

  state_e            state_q, state_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic              sec_tick_q, sec_tick_d;
  logic              timer_enable_q, timer_enable_d;
  logic              maxed_q, maxed_d;

  logic              pulse_ok;
  logic              ms_last;
  logic              sec_adv;
  logic              c_so, c_st, c_mo, c_mt;
  logic              sat;

  assign pulse_ok = (state_q == ST_RUNNING) && one_ms_pulse && !clear;
  assign ms_last  = (ms_q == MS_W'(MS_PER_SEC - 1));
  assign sec_adv  = pulse_ok && ms_last;
  // A carry out of the minutes-tens digit can only happen when advancing
  // from 99:59; it freezes every digit and drives the MAXED transition.
  assign sat      = c_mt;

  always_comb begin
    state_d    = state_q;
    ms_d       = ms_q;
    sec_tick_d = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      ms_d    = '0;
    end else begin
      case (state_q)
        ST_RUNNING: if (pause) state_d = ST_PAUSED;
        ST_IDLE,
        ST_PAUSED:  if (!pause && start) state_d = ST_RUNNING;
        default:    ;
      endcase
      // A pulse coinciding with pause is still counted.
      if (pulse_ok) begin
        if (ms_last) begin
          ms_d       = '0;
          sec_tick_d = 1'b1;
        end else begin
          ms_d = ms_q + MS_W'(1);
        end
      end
      if (sat) state_d = ST_MAXED;
    end
    timer_enable_d = (state_d == ST_RUNNING);
    maxed_d        = (state_d == ST_MAXED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ms_q           <= '0;
      sec_tick_q     <= 1'b0;
      timer_enable_q <= 1'b0;
      maxed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ms_q           <= ms_d;
      sec_tick_q     <= sec_tick_d;
      timer_enable_q <= timer_enable_d;
      maxed_q        <= maxed_d;
    end
  end

  game_clock_bcd_digit #(.WRAP(BCD_NINE)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(sec_adv), .freeze(sat),
    .digit(sec_ones), .carry(c_so)
  );

  game_clock_bcd_digit #(.WRAP(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_so), .freeze(sat),
    .digit(sec_tens), .carry(c_st)
  );

  game_clock_bcd_digit #(.WRAP(BCD_NINE)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_st), .freeze(sat),
    .digit(min_ones), .carry(c_mo)
  );

  game_clock_bcd_digit #(.WRAP(BCD_NINE)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_mo), .freeze(sat),
    .digit(min_tens), .carry(c_mt)
  );

  assign timer_enable = timer_enable_q;
  assign sec_tick     = sec_tick_q;
  assign maxed        = maxed_q;

endmodule

// File: tb/tb_game_clock.sv
module tb_game_clock;

  localparam int MS = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_MAX   = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       clear;
  logic       one_ms_pulse;
  logic       timer_enable;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       sec_tick;
  logic       maxed;

  logic [18:0] dut_vec;
  logic [15:0] dut_digits;

  int n_checks;
  int n_pass;

  // Reference model: elapsed whole seconds plus a partial-second ms count.
  int m_state;
  int m_ms;
  int m_secs;
  logic m_tick;

  game_clock #(.MS_PER_SEC(MS), .MS_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .one_ms_pulse(one_ms_pulse), .timer_enable(timer_enable),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .sec_tick(sec_tick), .maxed(maxed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_digits = {min_tens, min_ones, sec_tens, sec_ones};
  assign dut_vec    = {timer_enable, sec_tick, maxed, dut_digits};

  function automatic logic [18:0] exp_vec();
    int mm;
    int ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    return {(m_state == M_RUN), m_tick, (m_state == M_MAX),
            4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_ms    = 0;
    m_secs  = 0;
    m_tick  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic c, input logic pl);
    int pre;
    pre    = m_state;
    m_tick = 1'b0;
    if (c) begin
      model_reset();
    end else begin
      if (pre == M_RUN && p) m_state = M_PAUSE;
      else if ((pre == M_IDLE || pre == M_PAUSE) && !p && s) m_state = M_RUN;
      if (pre == M_RUN && pl) begin
        if (m_ms == MS - 1) begin
          m_ms   = 0;
          m_tick = 1'b1;
          if (m_secs == 99 * 60 + 59) m_state = M_MAX;
          else m_secs++;
        end else begin
          m_ms++;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic cycle(input logic s, input logic p, input logic c, input logic pl);
    start        = s;
    pause        = p;
    clear        = c;
    one_ms_pulse = pl;
    @(posedge clk);
    model_step(s, p, c, pl);
    #1;
    start        = 1'b0;
    pause        = 1'b0;
    clear        = 1'b0;
    one_ms_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if (dut_vec !== 19'd0) $display("FAIL reset_hold got %h want %h", dut_vec, 19'd0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_release got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (timer_enable !== 1'b1) $display("FAIL start_enable got %b want 1", timer_enable);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (sec_tick !== ((i == 3) || (i == 7)))
        $display("FAIL basic_tick pulse %0d got %b want %b", i + 1, sec_tick, (i == 3) || (i == 7));
      else n_pass++;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL basic_vec got %h want %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (dut_digits !== 16'h0002) $display("FAIL basic_digits got %h want 0002", dut_digits);
    else n_pass++;
  endtask

  task automatic test_rollover();
    for (int i = 0; i < 57 * MS; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL roll_vec got %h want %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (dut_digits !== 16'h0059) $display("FAIL roll_0059 got %h want 0059", dut_digits);
    else n_pass++;
    for (int i = 0; i < MS; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({dut_digits, sec_tick} !== {16'h0100, 1'b1})
      $display("FAIL roll_0100 got %h/%b want 0100/1", dut_digits, sec_tick);
    else n_pass++;
    for (int i = 0; i < 539 * MS; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL roll_vec2 got %h want %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (dut_digits !== 16'h0959) $display("FAIL roll_0959 got %h want 0959", dut_digits);
    else n_pass++;
    for (int i = 0; i < MS; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_digits !== 16'h1000) $display("FAIL roll_1000 got %h want 1000", dut_digits);
    else n_pass++;
  endtask

  task automatic test_pause();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (timer_enable !== 1'b0) $display("FAIL pause_enable got %b want 0", timer_enable);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({timer_enable, dut_digits} !== {1'b0, 16'h0000})
        $display("FAIL paused_hold got %b/%h want 0/0000", timer_enable, dut_digits);
      else n_pass++;
    end
    // start together with pause while PAUSED: pause wins
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (timer_enable !== 1'b0) $display("FAIL pause_beats_start got %b want 0", timer_enable);
    else n_pass++;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({dut_digits, sec_tick} !== {16'h0001, 1'b1})
      $display("FAIL pause_resume got %h/%b want 0001/1", dut_digits, sec_tick);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int ticks;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5999 * MS; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL sat_run got %h want %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({dut_digits, maxed} !== {16'h9959, 1'b0})
      $display("FAIL sat_9959 got %h/%b want 9959/0", dut_digits, maxed);
    else n_pass++;
    ticks = 0;
    for (int i = 0; i < MS; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (sec_tick === 1'b1) ticks++;
    end
    n_checks++;
    if ({dut_digits, maxed, timer_enable} !== {16'h9959, 1'b1, 1'b0} || ticks != 1)
      $display("FAIL sat_enter got %h/%b/%b ticks %0d want 9959/1/0 ticks 1",
               dut_digits, maxed, timer_enable, ticks);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cycle(i[0], 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({dut_digits, maxed, timer_enable, sec_tick} !== {16'h9959, 1'b1, 1'b0, 1'b0})
        $display("FAIL sat_hold got %h/%b/%b/%b want 9959/1/0/0",
                 dut_digits, maxed, timer_enable, sec_tick);
      else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({dut_digits, maxed, timer_enable} !== {16'h0000, 1'b0, 1'b0})
      $display("FAIL sat_clear got %h/%b/%b want 0000/0/0", dut_digits, maxed, timer_enable);
    else n_pass++;
    for (int i = 0; i < MS + 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_digits !== 16'h0000) $display("FAIL idle_ignores got %h want 0000", dut_digits);
    else n_pass++;
  endtask

  task automatic test_clear_combo();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * MS + 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_digits !== 16'h0003) $display("FAIL combo_pre got %h want 0003", dut_digits);
    else n_pass++;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({dut_digits, timer_enable, sec_tick, maxed} !== {16'h0000, 3'b000})
      $display("FAIL combo_clear got %h/%b/%b/%b want 0000/0/0/0",
               dut_digits, timer_enable, sec_tick, maxed);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL combo_model got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5 * MS; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({dut_digits, timer_enable} !== {16'h0005, 1'b1})
      $display("FAIL areset_pre got %h/%b want 0005/1", dut_digits, timer_enable);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== 19'd0) $display("FAIL areset_now got %h want %h", dut_vec, 19'd0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL areset_after got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    logic s, p, c, pl;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 63) == 0);
      pl = ($urandom_range(0, 1) == 1);
      cycle(s, p, c, pl);
      n_checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL random cycle %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    pause        = 1'b0;
    clear        = 1'b0;
    one_ms_pulse = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_rollover();
    test_pause();
    test_saturate();
    test_clear_combo();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_clock.md
Name: game_clock

Overview:
- Elapsed-time clock for a Sudoku game session.
- Consumes the 1 ms pulse from the millisecond timer and drives that timer's enable.
- Accumulates milliseconds into BCD minutes:seconds (MM:SS) for the seven-segment display driver.
- Supports start, pause and clear commands from the game controller, and saturates at 99:59.

Parameters:
MS_PER_SEC, 1000, number of ms pulses per second (set small, e.g. 4, for simulation)
MS_W, 10, width of the internal ms counter; must satisfy 2^MS_W >= MS_PER_SEC

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  level/pulse; begin or resume counting
pause  in  1  level/pulse; suspend counting
clear  in  1  level/pulse; zero time and return to idle
one_ms_pulse  in  1  single-cycle tick from the ms timer
timer_enable  out  1  enable to the ms timer; high only while RUNNING
sec_ones  out  4  BCD seconds units, 0-9
sec_tens  out  4  BCD seconds tens, 0-5
min_ones  out  4  BCD minutes units, 0-9
min_tens  out  4  BCD minutes tens, 0-9
sec_tick  out  1  one-cycle pulse each time the seconds value advances
maxed  out  1  high while saturated at 99:59

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - ms_count = 0.
  - All BCD digits = 0.
  - timer_enable, sec_tick and maxed = 0.
- States: IDLE, RUNNING, PAUSED, MAXED (2-bit encoding). Registered state updates on posedge clk.
- Command priority: clear > pause > start.
  - clear, from any state: next state IDLE, ms_count and digits zeroed next edge, maxed=0.
  - pause, RUNNING only: -> PAUSED; ignored in other states.
  - start, IDLE or PAUSED only: -> RUNNING; ignored in RUNNING and MAXED.
- timer_enable = 1 iff state == RUNNING. This is a registered output, so it follows the state with no extra delay.
- Counting happens only while state == RUNNING, with no clear this cycle, and one_ms_pulse = 1:
  - If ms_count == MS_PER_SEC-1: ms_count <= 0, advance seconds, sec_tick <= 1 for one cycle.
  - Otherwise ms_count <= ms_count+1.
- Seconds advance, BCD ripple:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 (i.e. :59->:00) carries into min_ones.
  - min_ones 9->0 carries into min_tens.
- Saturation: if the advance occurs at 99:59, digits hold 99:59, state -> MAXED, maxed=1, and sec_tick still pulses. In MAXED, pulses are ignored; only clear exits.
- pause and one_ms_pulse in the same RUNNING cycle: the pulse IS counted. The state leaves RUNNING on that same edge.
- ms_count is retained across PAUSED; the partial second resumes on start. The ms timer's own sub-ms count is lost because its enable drops; this is accepted.
- one_ms_pulse outside RUNNING is ignored.
- Simultaneous start+pause in PAUSED: pause wins, so the state stays PAUSED.
- Reset mid-count zeroes everything asynchronously; no pulse is emitted.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=0, ST_RUNNING=1, ST_PAUSED=2, ST_MAXED=3;
  - BCD_MAX_SEC_TENS=5 and BCD_NINE=9.
- One natural sub-module, bcd_digit: a 4-bit BCD counter with inc, configurable wrap value, carry out, and async reset.
  - game_clock instantiates four of these, chained through carries.
  - The top level keeps the FSM, ms counter and saturation detect.

Test Plan (MS_PER_SEC=4):
1. Reset then start, 8 ms pulses:
   - digits 00:02;
   - sec_tick high exactly on the cycles after pulses 4 and 8;
   - timer_enable=1 from the cycle after start.
2. Run to 00:59, then 4 more pulses:
   - 01:00, sec_tens wraps 5->0;
   - continue to 09:59 -> 10:00 with min_tens=1.
3. Pause after 2 pulses, apply 5 pulses while PAUSED:
   - digits unchanged, timer_enable=0;
   - start, then 2 pulses -> 00:01 (ms_count resumed from 2).
4. Force 99:59 (run or preload), then 4 pulses:
   - digits stay 99:59, maxed=1, one sec_tick;
   - further pulses and start give no change;
   - clear -> 00:00, maxed=0, IDLE.
5. Simultaneous clear+pause+one_ms_pulse while RUNNING at 00:03: next cycle 00:00, IDLE, timer_enable=0, no sec_tick.
6. Assert rst asynchronously mid-clock-period during RUNNING at 00:05: all outputs 0 immediately, without waiting for a clock edge.
